spi_hex_streamer: RTL and testbench
===================================

Name: spi_hex_streamer

Overview:
- Downstream of the SPI decoder and upstream of the UART transmitter in the sniffer top.
- Buffers captured bytes in a small FIFO and renders each one as two uppercase ASCII hex characters plus a separator.
- Drives the transmitter's start/busy handshake, so the top no longer sequences nibbles itself.
- The end of an SPI frame, or a full line of bytes, produces CR LF instead of a space.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.
- BYTES_PER_LINE, 16: bytes per output line before a forced CR LF; range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte available.
- in_data  input  8  captured SPI byte.
- in_last  input  1  byte is the final one of its CSN frame.
- in_ready  output  1  FIFO can accept; equals not-full.
- tx_busy  input  1  transmitter busy flag.
- tx_start  output  1  one-cycle strobe to launch tx_data.
- tx_data  output  8  ASCII character for the transmitter.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  8  saturating count of bytes lost to overflow.

Behaviour:
- Reset (rst high at a rising edge) sets: tx_start=0, tx_data=8'h20, FIFO empty, level=0, in_ready=1, drop_cnt=0, line counter=0, FSM=IDLE. Reset mid-character abandons the character; the transmitter finishes on its own.
- Write: when in_valid && in_ready, {in_last,in_data} is pushed.
- Overflow: in_valid && !in_ready drops the byte; drop_cnt increments and saturates at 255.
- Full with simultaneous pop: in_ready is registered-full based, so no write is accepted that cycle.
- Read: the FIFO pops only when the FSM leaves IDLE. Read data is registered into a byte/last holding register in that same cycle.
- FSM states: IDLE, HI, LO, SEP, CR, LF, GAP.
  - IDLE to HI when the FIFO is not empty (pop).
  - HI/LO/SEP/CR/LF each emit one character. Each asserts tx_start for exactly one cycle when tx_busy=0, with tx_data registered in the same cycle, then moves to GAP.
  - GAP lasts exactly one cycle, ignores tx_busy (the transmitter raises busy one cycle late), then goes to the next character state.
- Character order per byte:
  - HI, then LO.
  - Then SEP (8'h20) if !last && line_cnt != BYTES_PER_LINE-1.
  - Otherwise CR (8'h0D) then LF (8'h0A), and line_cnt is cleared.
  - After SEP, line_cnt increments.
  - After the final character the FSM returns to IDLE.
- Nibble encoding: 0..9 map to 8'h30+n; A..F map to 8'h37+n (uppercase). The nibble is 4 bits, zero-extended to 8 bits before the add.
- Latency: with the FSM idle, tx_busy=0 and the FIFO empty, a byte accepted at edge t gives tx_start high in the cycle after edge t+2.
- Throughput is bounded by the UART. The FIFO absorbs bursts; level is valid every cycle.
- tx_busy held high stalls the FSM indefinitely. Writes continue until full.
- in_last on a byte with line_cnt==BYTES_PER_LINE-1 produces a single CR LF, not two.

Decomposition:
- Shared include file holds ASCII localparams (CHAR_SPACE, CHAR_CR, CHAR_LF, HEX_DIGIT_BASE=8'h30, HEX_ALPHA_BASE=8'h37) and the FSM state encodings. The sniffer top and future text emitters reuse it.
- One sub-module: sync_fifo (9-bit wide, DEPTH entries, push/pop/full/empty/level, synchronous active-high reset). It is reusable for the decoder side.

Test Plan:
- Single byte 8'hBC, in_last=0, tx_busy model 10 cycles per char -> tx_data sequence 8'h42, 8'h43, 8'h20. The first tx_start comes 2 cycles after the write, and there is exactly one strobe per character.
- Byte 8'h25, in_last=1 -> 8'h32, 8'h35, 8'h0D, 8'h0A. line_cnt returns to 0; a following byte 8'h0F then gives 8'h30, 8'h46, 8'h20.
- BYTES_PER_LINE=4, bytes 00,01,02,03,04 with no last -> CR LF after "03" only. "04" starts the new line, followed by a space.
- tx_busy held high, push DEPTH+3 bytes -> in_ready drops after DEPTH accepts, drop_cnt=3, level=DEPTH. Releasing busy drains in order with no data corruption.
- 300 overflow attempts while full -> drop_cnt saturates at 255.
- Assert rst while in LO with 5 bytes queued -> next cycle tx_start=0, level=0, in_ready=1, drop_cnt=0. A new byte 8'hA5 then emits 8'h41, 8'h35, 8'h20.

Source files
------------

// File: rtl/spi_hex_streamer_pkg.sv
// Shared text-rendering constants and FSM encoding for the SPI sniffer's character emitters.
package spi_hex_streamer_pkg;

   localparam logic [7:0] CHAR_SPACE     = 8'h20;
   localparam logic [7:0] CHAR_CR        = 8'h0D;
   localparam logic [7:0] CHAR_LF        = 8'h0A;
   localparam logic [7:0] HEX_DIGIT_BASE = 8'h30;
   localparam logic [7:0] HEX_ALPHA_BASE = 8'h37;

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      SEP,
      CR,
      LF,
      GAP
   } state_e;

   // Uppercase ASCII for one nibble; the nibble is zero-extended before the add.
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] ext;
      ext = {4'h0, nib};
      return (nib < 4'd10) ? (HEX_DIGIT_BASE + ext) : (HEX_ALPHA_BASE + ext);
   endfunction

endpackage

// File: rtl/spi_hex_streamer_if.sv
// Byte-in / character-out bundle between the SPI decoder, the hex streamer and the UART transmitter.
interface spi_hex_streamer_if #(
   parameter int DEPTH = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_last;
   logic          in_ready;
   logic          tx_busy;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic [LW-1:0] level;
   logic [7:0]    drop_cnt;

   modport master (
      output in_valid, in_data, in_last, tx_busy,
      input  in_ready, tx_start, tx_data, level, drop_cnt
   );

   modport slave (
      input  in_valid, in_data, in_last, tx_busy,
      output in_ready, tx_start, tx_data, level, drop_cnt
   );

endinterface

// File: rtl/spi_hex_streamer_sync_fifo.sv
// Single-clock FIFO with occupancy output; pointers carry one extra bit so full and empty stay distinct.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

   assign level_o = wr_q - rd_q;
   assign full_o  = (level_o == FULL_LVL);
   assign empty_o = (wr_q == rd_q);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/spi_hex_streamer.sv
// Buffers captured SPI bytes and streams them to the UART as "HH " text, ending lines with CR LF.
module spi_hex_streamer
   import spi_hex_streamer_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int BYTES_PER_LINE = 16
) (
   input  logic               clk,
   input  logic               rst,
   spi_hex_streamer_if.slave  bus
);
   localparam int         LW       = $clog2(DEPTH) + 1;
   localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

   state_e        state_q, state_d;
   state_e        nxt_q, nxt_d;
   logic [7:0]    line_q, line_d;
   logic [7:0]    drop_q, drop_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    byte_q;
   logic          last_q;
   logic          pop;
   logic [8:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [LW-1:0] fifo_level;

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.in_valid),
      .din_i   ({bus.in_last, bus.in_data}),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_comb begin
      drop_d = drop_q;
      if (bus.in_valid && fifo_full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   // Character states launch only when the transmitter is idle; GAP covers its one-cycle busy lag.
   always_comb begin
      state_d    = state_q;
      nxt_d      = nxt_q;
      line_d     = line_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = HI;
            end
         end
         HI: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = hex_char(byte_q[7:4]);
               nxt_d      = LO;
               state_d    = GAP;
            end
         end
         LO: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = hex_char(byte_q[3:0]);
               nxt_d      = (!last_q && (line_q != LAST_COL)) ? SEP : CR;
               state_d    = GAP;
            end
         end
         SEP: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = CHAR_SPACE;
               line_d     = line_q + 8'd1;
               nxt_d      = IDLE;
               state_d    = GAP;
            end
         end
         CR: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = CHAR_CR;
               line_d     = 8'd0;
               nxt_d      = LF;
               state_d    = GAP;
            end
         end
         LF: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = CHAR_LF;
               nxt_d      = IDLE;
               state_d    = GAP;
            end
         end
         GAP:     state_d = nxt_q;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         nxt_q      <= IDLE;
         line_q     <= 8'd0;
         drop_q     <= 8'd0;
         tx_start_q <= 1'b0;
         tx_data_q  <= CHAR_SPACE;
      end else begin
         state_q    <= state_d;
         nxt_q      <= nxt_d;
         line_q     <= line_d;
         drop_q     <= drop_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) {last_q, byte_q} <= fifo_dout;
   end

   assign bus.in_ready = !fifo_full;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.level    = fifo_level;
   assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_spi_hex_streamer.sv
// Scoreboard bench: pushes bytes, models the expected ASCII stream and compares the transmitter strobes.
module tb_spi_hex_streamer;
   localparam int DEPTH = 16;
   localparam int BPL   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_hex_streamer_if #(.DEPTH(DEPTH)) bus ();

   spi_hex_streamer #(
      .DEPTH          (DEPTH),
      .BYTES_PER_LINE (BPL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         busy_cnt = 0;
   bit         busy_hold = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         obs_cyc_q[$];
   int         m_line = 0;
   int         w_cyc = 0;
   bit         w_acc = 1'b0;
   string      hexs = "0123456789ABCDEF";

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: busy rises the edge after a start strobe and lasts 10 cycles.
   always @(posedge clk) begin
      if (bus.tx_start === 1'b1) busy_cnt <= 10;
      else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
   end
   assign bus.tx_busy = busy_hold | (busy_cnt != 0);

   always @(negedge clk) begin
      if (bus.tx_start === 1'b1) begin
         obs_q.push_back(bus.tx_data);
         obs_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic void model_push(input logic [7:0] d, input bit last);
      exp_q.push_back(8'(hexs[d[7:4]]));
      exp_q.push_back(8'(hexs[d[3:0]]));
      if (!last && m_line != BPL - 1) begin
         exp_q.push_back(8'h20);
         m_line++;
      end else begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         m_line = 0;
      end
   endfunction

   task automatic push_byte(input logic [7:0] d, input bit last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      w_acc = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (w_acc) begin
         model_push(d, last);
         w_cyc = cyc;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
      m_line = 0;
   endtask

   task automatic wait_out(input int budget, output bit to);
      int n = 0;
      while (obs_q.size() < exp_q.size() && n < budget) begin
         @(negedge clk);
         n++;
      end
      to = (obs_q.size() < exp_q.size());
      repeat (30) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
      checks++; if (bus.tx_data !== 8'h20) begin errors++; $display("FAIL reset_tx_data: got %02h expected 20", bus.tx_data); end
      checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); end
   endtask

   task automatic test_single();
      bit to;
      logic [7:0] e, o;
      int lat;
      do_reset();
      push_byte(8'hBC, 1'b0);
      wait_out(200, to);
      checks++; if (to) begin errors++; $display("FAIL single_timeout: got %0d chars expected %0d", obs_q.size(), exp_q.size()); end
      lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - w_cyc : -1;
      checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d cycles expected 2", lat); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL single_char: got %02h expected %02h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic test_frame_end();
      bit to1, to2;
      logic [7:0] e, o;
      push_byte(8'h25, 1'b1);
      wait_out(300, to1);
      push_byte(8'h0F, 1'b0);
      wait_out(300, to2);
      checks++; if (to1 || to2) begin errors++; $display("FAIL frame_timeout: got %0d chars expected %0d", obs_q.size(), exp_q.size()); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL frame_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL frame_char: got %02h expected %02h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic test_line_wrap();
      bit to;
      logic [7:0] e, o;
      do_reset();
      for (int i = 0; i < 5; i++) push_byte(8'(i), 1'b0);
      wait_out(1000, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_timeout: got %0d chars expected %0d", obs_q.size(), exp_q.size()); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL wrap_char: got %02h expected %02h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic test_backpressure();
      bit to;
      int acc = 0;
      logic [7:0] e, o;
      do_reset();
      busy_hold = 1'b1;
      push_byte(8'h5A, 1'b0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < DEPTH + 3; i++) begin
         push_byte(8'($urandom_range(0, 255)), 1'b0);
         if (w_acc) acc++;
      end
      checks++; if (acc !== DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d expected %0d", acc, DEPTH); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (bus.level !== 5'(DEPTH)) begin errors++; $display("FAIL bp_level: got %0d expected %0d", bus.level, DEPTH); end
      checks++; if (bus.drop_cnt !== 8'd3) begin errors++; $display("FAIL bp_drop_cnt: got %0d expected 3", bus.drop_cnt); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL bp_stall: got %0d strobes while busy expected 0", obs_q.size()); end
      busy_hold = 1'b0;
      wait_out(4000, to);
      checks++; if (to) begin errors++; $display("FAIL bp_timeout: got %0d chars expected %0d", obs_q.size(), exp_q.size()); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL bp_char: got %02h expected %02h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic test_saturate();
      do_reset();
      busy_hold = 1'b1;
      push_byte(8'h11, 1'b0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
      bus.in_valid = 1'b1;
      repeat (100) @(negedge clk);
      checks++; if (bus.drop_cnt !== 8'd100) begin errors++; $display("FAIL sat_drop_mid: got %0d expected 100", bus.drop_cnt); end
      repeat (200) @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop_cnt: got %0d expected 255", bus.drop_cnt); end
      checks++; if (bus.level !== 5'(DEPTH)) begin errors++; $display("FAIL sat_level: got %0d expected %0d", bus.level, DEPTH); end
      busy_hold = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit to;
      int n = 0;
      logic [7:0] e, o;
      do_reset();
      while (busy_cnt != 0 && n < 50) begin @(negedge clk); n++; end
      for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i), 1'b0);
      n = 0;
      while (obs_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
      checks++; if (obs_q.size() == 0) begin errors++; $display("FAIL rmid_first_char: got 0 strobes expected 1"); end
      repeat (3) @(negedge clk);
      checks++; if (bus.level !== 5'd5) begin errors++; $display("FAIL rmid_queued: got %0d expected 5", bus.level); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rmid_tx_start: got %b expected 0", bus.tx_start); end
      checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL rmid_level: got %0d expected 0", bus.level); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop_cnt: got %0d expected 0", bus.drop_cnt); end
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
      m_line = 0;
      push_byte(8'hA5, 1'b0);
      wait_out(300, to);
      checks++; if (to) begin errors++; $display("FAIL rmid_timeout: got %0d chars expected %0d", obs_q.size(), exp_q.size()); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL rmid_char: got %02h expected %02h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      test_reset();
      test_single();
      test_frame_end();
      test_line_wrap();
      test_backpressure();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
